// File: rtl/gbt_link_tester_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : MCPkg
//  Description : Shared types for the GBT link tester (TX mode select,
//                pattern checker states).
//  Revision    : 1.0 - initial release
// ============================================================================
package MCPkg;

    typedef enum logic [1:0] {
        MODE_USER     = 2'd0,
        MODE_LOOPBACK = 2'd1,
        MODE_PATTERN  = 2'd2,
        MODE_IDLE     = 2'd3
    } mode_e;

    typedef enum logic [0:0] {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } chk_state_e;

endpackage : MCPkg
`default_nettype wire

// File: rtl/gbt_pattern_checker.sv
`default_nettype none
// ============================================================================
//  Module      : gbt_pattern_checker
//  Description : Counter-pattern checker with HUNT/LOCKED hysteresis and a
//                saturating error counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module gbt_pattern_checker
    import MCPkg::*;
#(
    parameter int DATA_W      = 80,
    parameter int LOCK_THRESH = 8,
    parameter int LOSS_THRESH = 4,
    parameter int ERR_W       = 16
) (
    input  logic              clk_ik,
    input  logic              rst_ir,
    input  logic [DATA_W-1:0] rx_data_ib,
    input  logic              rx_valid_i,
    input  logic              err_clear_i,
    output logic              locked_o,
    output logic [ERR_W-1:0]  err_cnt_ob,
    output logic              lock_lost_o
);

    localparam int CNT_W = $clog2(((LOCK_THRESH > LOSS_THRESH) ? LOCK_THRESH : LOSS_THRESH) + 1);
    localparam logic [CNT_W-1:0] c_LOCK_LAST = CNT_W'(LOCK_THRESH - 1);
    localparam logic [CNT_W-1:0] c_LOSS_LAST = CNT_W'(LOSS_THRESH - 1);

    chk_state_e        r_state;
    logic [DATA_W-1:0] r_stored;
    logic              r_seeded;
    logic [CNT_W-1:0]  r_good_cnt;
    logic [CNT_W-1:0]  r_bad_cnt;
    logic [ERR_W-1:0]  r_err;
    logic              r_locked;
    logic              r_lock_lost;
    logic              w_good;

    assign w_good = (rx_data_ib == r_stored + DATA_W'(1));

    always_ff @(posedge clk_ik) begin
        if (rst_ir) begin
            r_state     <= ST_HUNT;
            r_stored    <= '0;
            r_seeded    <= 1'b0;
            r_good_cnt  <= '0;
            r_bad_cnt   <= '0;
            r_err       <= '0;
            r_locked    <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            r_lock_lost <= 1'b0;
            if (rx_valid_i) begin
                r_stored <= rx_data_ib;
                // First frame after reset or loss of lock only seeds the reference
                if (!r_seeded) begin
                    r_seeded <= 1'b1;
                end else if (r_state == ST_HUNT) begin
                    if (!w_good) begin
                        r_good_cnt <= '0;
                    end else if (r_good_cnt == c_LOCK_LAST) begin
                        r_state    <= ST_LOCKED;
                        r_locked   <= 1'b1;
                        r_good_cnt <= '0;
                        r_bad_cnt  <= '0;
                    end else begin
                        r_good_cnt <= r_good_cnt + 1'b1;
                    end
                end else begin
                    if (w_good) begin
                        r_bad_cnt <= '0;
                    end else begin
                        if (r_err != '1) r_err <= r_err + 1'b1;
                        if (r_bad_cnt == c_LOSS_LAST) begin
                            r_state     <= ST_HUNT;
                            r_locked    <= 1'b0;
                            r_lock_lost <= 1'b1;
                            r_seeded    <= 1'b0;
                            r_bad_cnt   <= '0;
                            r_good_cnt  <= '0;
                        end else begin
                            r_bad_cnt <= r_bad_cnt + 1'b1;
                        end
                    end
                end
            end
            if (err_clear_i) r_err <= '0;
        end
    end

    assign locked_o    = r_locked;
    assign err_cnt_ob  = r_err;
    assign lock_lost_o = r_lock_lost;

endmodule : gbt_pattern_checker
`default_nettype wire

// File: rtl/gbt_link_tester.sv
`default_nettype none
// ============================================================================
//  Module      : gbt_link_tester
//  Description : GBT link tester - TX source mux with counter generator and
//                an independent RX counter-pattern checker.
//  Revision    : 1.0 - initial release
// ============================================================================
module gbt_link_tester
    import MCPkg::*;
#(
    parameter int DATA_W      = 80,
    parameter int LOCK_THRESH = 8,
    parameter int LOSS_THRESH = 4,
    parameter int ERR_W       = 16
) (
    input  logic              clk_ik,
    input  logic              rst_ir,
    input  logic [1:0]        mode_ib2,
    input  logic [DATA_W-1:0] user_data_ib,
    input  logic [DATA_W-1:0] rx_data_ib,
    input  logic              rx_valid_i,
    input  logic              err_clear_i,
    output logic [DATA_W-1:0] tx_data_ob,
    output logic              locked_o,
    output logic [ERR_W-1:0]  err_cnt_ob,
    output logic              lock_lost_o
);

    mode_e             w_mode;
    mode_e             r_mode_prev;
    logic [DATA_W-1:0] r_gen;
    logic [DATA_W-1:0] r_tx;
    logic [DATA_W-1:0] w_pat;
    logic [DATA_W-1:0] w_tx_next;

    assign w_mode = mode_e'(mode_ib2);

    // Entering PATTERN restarts the sequence so the first emitted frame is 0
    always_comb begin
        w_pat = (w_mode == MODE_PATTERN && r_mode_prev != MODE_PATTERN) ? '0 : r_gen;
        case (w_mode)
            MODE_USER:     w_tx_next = user_data_ib;
            MODE_LOOPBACK: w_tx_next = rx_data_ib;
            MODE_PATTERN:  w_tx_next = w_pat;
            default:       w_tx_next = '0;
        endcase
    end

    always_ff @(posedge clk_ik) begin
        if (rst_ir) begin
            r_tx        <= '0;
            r_gen       <= '0;
            r_mode_prev <= MODE_USER;
        end else begin
            r_tx        <= w_tx_next;
            r_mode_prev <= w_mode;
            if (w_mode == MODE_PATTERN) r_gen <= w_pat + DATA_W'(1);
        end
    end

    assign tx_data_ob = r_tx;

    gbt_pattern_checker #(
        .DATA_W      (DATA_W),
        .LOCK_THRESH (LOCK_THRESH),
        .LOSS_THRESH (LOSS_THRESH),
        .ERR_W       (ERR_W)
    ) u_checker (
        .clk_ik      (clk_ik),
        .rst_ir      (rst_ir),
        .rx_data_ib  (rx_data_ib),
        .rx_valid_i  (rx_valid_i),
        .err_clear_i (err_clear_i),
        .locked_o    (locked_o),
        .err_cnt_ob  (err_cnt_ob),
        .lock_lost_o (lock_lost_o)
    );

endmodule : gbt_link_tester
`default_nettype wire

// File: tb/tb_gbt_link_tester.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gbt_link_tester
//  Description : Scoreboard bench for gbt_link_tester; default instance (a)
//                and a narrow instance (b: DATA_W=8, ERR_W=4, LOSS=32).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gbt_link_tester;

    typedef struct {
        logic [79:0] tx;
        logic        locked;
        logic        lost;
        logic [15:0] err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic [79:0] user = '0;
    logic [79:0] ext_rx = '0;
    logic        use_ext = 1'b0;
    logic [79:0] corrupt = '0;
    logic        valid = 1'b0;
    logic        err_clear = 1'b0;

    logic [79:0] tx_a, rx_a;
    logic [7:0]  tx_b, rx_b;
    logic        locked_a, locked_b, lost_a, lost_b;
    logic [15:0] err_a;
    logic [3:0]  err_b;

    assign rx_a = use_ext ? ext_rx : (tx_a ^ corrupt);
    assign rx_b = use_ext ? ext_rx[7:0] : (tx_b ^ corrupt[7:0]);

    always #5 clk = ~clk;

    gbt_link_tester u_dut_a (
        .clk_ik(clk), .rst_ir(rst), .mode_ib2(mode), .user_data_ib(user),
        .rx_data_ib(rx_a), .rx_valid_i(valid), .err_clear_i(err_clear),
        .tx_data_ob(tx_a), .locked_o(locked_a), .err_cnt_ob(err_a), .lock_lost_o(lost_a)
    );

    gbt_link_tester #(.DATA_W(8), .LOCK_THRESH(8), .LOSS_THRESH(32), .ERR_W(4)) u_dut_b (
        .clk_ik(clk), .rst_ir(rst), .mode_ib2(mode), .user_data_ib(user[7:0]),
        .rx_data_ib(rx_b), .rx_valid_i(valid), .err_clear_i(err_clear),
        .tx_data_ob(tx_b), .locked_o(locked_b), .err_cnt_ob(err_b), .lock_lost_o(lost_b)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [79:0] act, input logic [79:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model state, index 0 = instance a, 1 = instance b
    logic [79:0] m_mask [2] = '{{80{1'b1}}, 80'hFF};
    logic [15:0] m_emax [2] = '{16'hFFFF, 16'h000F};
    int          m_lock [2] = '{8, 8};
    int          m_loss [2] = '{4, 32};
    logic [79:0] m_tx [2], m_gen [2], m_stored [2];
    logic [1:0]  m_prev [2];
    bit          m_seeded [2], m_locked [2], m_lost [2];
    int          m_good [2], m_bad [2];
    logic [15:0] m_err [2];

    exp_t sb_a[$];
    exp_t sb_b[$];

    task automatic model_step(input int i, output exp_t e);
        logic [79:0] rx, pat, msk;
        bit good;
        msk = m_mask[i];
        rx  = (use_ext ? ext_rx : (m_tx[i] ^ corrupt)) & msk;
        if (rst) begin
            m_tx[i] = '0; m_gen[i] = '0; m_stored[i] = '0; m_prev[i] = 2'd0;
            m_seeded[i] = 0; m_locked[i] = 0; m_lost[i] = 0;
            m_good[i] = 0; m_bad[i] = 0; m_err[i] = '0;
        end else begin
            pat = (mode == 2'd2 && m_prev[i] != 2'd2) ? 80'd0 : m_gen[i];
            case (mode)
                2'd0:    m_tx[i] = user & msk;
                2'd1:    m_tx[i] = rx;
                2'd2:    m_tx[i] = pat;
                default: m_tx[i] = '0;
            endcase
            if (mode == 2'd2) m_gen[i] = (pat + 80'd1) & msk;
            m_prev[i] = mode;
            m_lost[i] = 0;
            if (valid) begin
                if (!m_seeded[i]) begin
                    m_seeded[i] = 1;
                end else begin
                    good = (rx == ((m_stored[i] + 80'd1) & msk));
                    if (!m_locked[i]) begin
                        if (!good) m_good[i] = 0;
                        else if (m_good[i] + 1 == m_lock[i]) begin
                            m_locked[i] = 1; m_good[i] = 0; m_bad[i] = 0;
                        end else m_good[i]++;
                    end else if (good) begin
                        m_bad[i] = 0;
                    end else begin
                        if (m_err[i] != m_emax[i]) m_err[i]++;
                        if (m_bad[i] + 1 == m_loss[i]) begin
                            m_locked[i] = 0; m_lost[i] = 1; m_seeded[i] = 0;
                            m_bad[i] = 0; m_good[i] = 0;
                        end else m_bad[i]++;
                    end
                end
                m_stored[i] = rx;
            end
            if (err_clear) m_err[i] = '0;
        end
        e.tx = m_tx[i]; e.locked = m_locked[i]; e.lost = m_lost[i]; e.err = m_err[i];
    endtask

    task automatic cycle();
        exp_t ea, eb;
        model_step(0, ea); sb_a.push_back(ea);
        model_step(1, eb); sb_b.push_back(eb);
        @(posedge clk); #1;
        ea = sb_a.pop_front();
        eb = sb_b.pop_front();
        check_eq("a_tx", tx_a, ea.tx);
        check_eq("a_locked", {79'd0, locked_a}, {79'd0, ea.locked});
        check_eq("a_lost", {79'd0, lost_a}, {79'd0, ea.lost});
        check_eq("a_err", {64'd0, err_a}, {64'd0, ea.err});
        check_eq("b_tx", {72'd0, tx_b}, eb.tx);
        check_eq("b_locked", {79'd0, locked_b}, {79'd0, eb.locked});
        check_eq("b_lost", {79'd0, lost_b}, {79'd0, eb.lost});
        check_eq("b_err", {76'd0, err_b}, {64'd0, eb.err});
    endtask

    function automatic logic [79:0] rnd80();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        logic [79:0] seq, held;
        @(posedge clk); #1;
        cycle(); cycle();
        check_eq("rst_tx", tx_a, 80'd0);
        check_eq("rst_locked", {79'd0, locked_a}, 80'd0);

        // Pattern loopback: seed + 8 good frames to lock
        rst = 1'b0; mode = 2'd2; valid = 1'b0;
        cycle();
        check_eq("pat_first", tx_a, 80'd0);
        valid = 1'b1;
        for (int k = 0; k < 9; k++) begin
            cycle();
            check_eq("pat_seq", tx_a, 80'(k + 1));
            check_eq("lock_at9", {79'd0, locked_a}, {79'd0, (k == 8)});
            check_eq("b_lock_at9", {79'd0, locked_b}, {79'd0, (k == 8)});
        end
        check_eq("lock_err0", {64'd0, err_a}, 80'd0);

        // Narrow generator wrap 254,255,0,1
        for (int k = 0; k < 244; k++) cycle();
        check_eq("b_pre_wrap", {72'd0, tx_b}, 80'd253);
        cycle(); check_eq("b_wrap0", {72'd0, tx_b}, 80'd254);
        cycle(); check_eq("b_wrap1", {72'd0, tx_b}, 80'd255);
        cycle(); check_eq("b_wrap2", {72'd0, tx_b}, 80'd0);
        cycle(); check_eq("b_wrap3", {72'd0, tx_b}, 80'd1);
        cycle();
        check_eq("b_wrap_err", {76'd0, err_b}, 80'd0);
        check_eq("b_wrap_lock", {79'd0, locked_b}, 80'd1);

        // One corrupted frame costs two bad frames, lock held
        corrupt = 80'h80;
        cycle();
        corrupt = '0;
        for (int k = 0; k < 3; k++) cycle();
        check_eq("corrupt_err", {64'd0, err_a}, 80'd2);
        check_eq("corrupt_lock", {79'd0, locked_a}, 80'd1);

        // Four bad frames drop lock on a with a single pulse
        use_ext = 1'b1; ext_rx = 80'h3C;
        for (int k = 0; k < 4; k++) begin
            cycle();
            check_eq("loss_pulse", {79'd0, lost_a}, {79'd0, (k == 3)});
            check_eq("loss_locked", {79'd0, locked_a}, {79'd0, (k < 3)});
        end
        check_eq("loss_err", {64'd0, err_a}, 80'd6);

        // Saturation on narrow counter
        for (int k = 0; k < 14; k++) cycle();
        check_eq("b_sat", {76'd0, err_b}, 80'd15);
        check_eq("b_sat_lock", {79'd0, locked_b}, 80'd1);
        check_eq("hunt_noerr", {64'd0, err_a}, 80'd6);
        err_clear = 1'b1;
        cycle();
        err_clear = 1'b0;
        check_eq("clr_b", {76'd0, err_b}, 80'd0);
        check_eq("clr_a", {64'd0, err_a}, 80'd0);

        // Valid toggling over a clean counter stream
        seq = 80'h3D;
        for (int k = 0; k < 40; k++) begin
            if (k % 2 == 0) begin valid = 1'b1; ext_rx = seq; seq = seq + 80'd1; end
            else begin valid = 1'b0; ext_rx = rnd80(); end
            cycle();
        end
        check_eq("tog_lock_a", {79'd0, locked_a}, 80'd1);
        check_eq("tog_err_a", {64'd0, err_a}, 80'd0);
        check_eq("tog_err_b", {76'd0, err_b}, 80'd0);

        // TX source modes with checker idle
        valid = 1'b0;
        mode = 2'd0;
        for (int k = 0; k < 3; k++) begin
            user = rnd80(); held = user;
            cycle();
            check_eq("user_tx", tx_a, held);
        end
        mode = 2'd1;
        for (int k = 0; k < 3; k++) begin
            ext_rx = rnd80(); held = ext_rx;
            cycle();
            check_eq("loop_tx", tx_a, held);
        end
        mode = 2'd3;
        cycle();
        check_eq("idle_tx", tx_a, 80'd0);
        mode = 2'd2;
        cycle(); check_eq("repat0", tx_a, 80'd0);
        cycle(); check_eq("repat1", tx_a, 80'd1);

        // Reset mid-run overrides clear, valid and corruption
        use_ext = 1'b0; valid = 1'b1;
        for (int k = 0; k < 12; k++) cycle();
        rst = 1'b1; err_clear = 1'b1; corrupt = 80'h5;
        cycle();
        check_eq("mrst_tx", tx_a, 80'd0);
        check_eq("mrst_lock", {79'd0, locked_a}, 80'd0);
        check_eq("mrst_err", {64'd0, err_a}, 80'd0);
        check_eq("mrst_lost", {79'd0, lost_a}, 80'd0);
        check_eq("mrst_b_tx", {72'd0, tx_b}, 80'd0);
        rst = 1'b0; err_clear = 1'b0; corrupt = '0; valid = 1'b0;
        cycle();
        check_eq("post_rst_lock", {79'd0, locked_a}, 80'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_gbt_link_tester
`default_nettype wire

// File: doc/gbt_link_tester.md
GBT_LINK_TESTER -- requirements
Module: gbt_link_tester

Interface
REQ-001 SHALL have parameter DATA_W, default 80, GBT frame data width in bits.
REQ-002 SHALL have parameter LOCK_THRESH, default 8, consecutive good frames needed to declare lock.
REQ-003 SHALL have parameter LOSS_THRESH, default 4, consecutive bad frames needed to drop lock.
REQ-004 SHALL have parameter ERR_W, default 16, error counter width.
REQ-005 SHALL have port clk_ik, input, 1, single clock (40 MHz GBT frame clock); all logic in this domain.
REQ-006 SHALL have port rst_ir, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have port mode_ib2, input, 2, TX source select: 0 USER, 1 LOOPBACK, 2 PATTERN, 3 IDLE.
REQ-008 SHALL have port user_data_ib, input, DATA_W, user TX frame.
REQ-009 SHALL have port rx_data_ib, input, DATA_W, received GBT frame.
REQ-010 SHALL have port rx_valid_i, input, 1, rx_data_ib qualifier; frames with rx_valid_i=0 are ignored.
REQ-011 SHALL have port err_clear_i, input, 1, single-cycle clear of the error counter.
REQ-012 SHALL have port tx_data_ob, output, DATA_W, frame to GBT transmitter.
REQ-013 SHALL have port locked_o, output, 1, checker locked to counter pattern.
REQ-014 SHALL have port err_cnt_ob, output, ERR_W, saturating mismatch count.
REQ-015 SHALL have port lock_lost_o, output, 1, one-cycle pulse on LOCKED->HUNT transition.

Function
REQ-016 tx_data_ob SHALL be registered, latency 1 cycle from the selected source.
REQ-017 USER: tx_data_ob = user_data_ib of the previous cycle.
REQ-018 LOOPBACK: tx_data_ob = rx_data_ib of the previous cycle, regardless of rx_valid_i.
REQ-019 PATTERN: tx_data_ob SHALL be a DATA_W-bit up-counter, +1 per cycle, wrapping all-ones -> 0.
REQ-020 The generator counter SHALL load 0 in the cycle mode_ib2 changes to PATTERN, so the first pattern frame is 0.
REQ-021 IDLE: tx_data_ob = 0.
REQ-022 The checker SHALL store the last valid rx frame and mark a valid frame good iff it equals stored+1 mod 2^DATA_W.
REQ-023 The first valid frame after reset, or after entering HUNT, SHALL only seed the stored value and is neither good nor bad.
REQ-024 Checker FSM states SHALL be HUNT and LOCKED; reset state is HUNT.
REQ-025 HUNT->LOCKED SHALL occur on the LOCK_THRESH-th consecutive good frame; a bad frame restarts the count at 0.
REQ-026 LOCKED->HUNT SHALL occur on the LOSS_THRESH-th consecutive bad frame; a good frame restarts the count at 0.
REQ-027 locked_o SHALL be 1 exactly in LOCKED, updating in the cycle after the deciding frame.
REQ-028 err_cnt_ob SHALL increment by 1 per bad frame in LOCKED only, saturate at all-ones, and never wrap.
REQ-029 err_clear_i SHALL zero err_cnt_ob next cycle; clear wins over a simultaneous increment.
REQ-030 The checker SHALL run independently of mode_ib2.
REQ-031 Invalid cycles (rx_valid_i=0) SHALL not change the FSM, the counters or the stored value.

Reset
REQ-032 On rst_ir: tx_data_ob=0, generator=0, FSM=HUNT, locked_o=0, lock_lost_o=0, err_cnt_ob=0, good/bad counters=0, seed flag cleared.
REQ-033 rst_ir asserted mid-operation SHALL take effect next edge and override every other input, err_clear_i included.

Structure
REQ-034 The mode enum (USER, LOOPBACK, PATTERN, IDLE) SHALL live in the shared package MCPkg.
REQ-035 The checker (FSM, threshold counters, error counter) SHALL be a sub-module gbt_pattern_checker; the TX mux and generator stay in the top.

Verification
REQ-036 mode=PATTERN, rx_data_ib tied to tx_data_ob, rx_valid_i=1 -> tx sequence 0,1,2...; locked_o=1 after seed + 8 good frames; err_cnt_ob=0.
REQ-037 Locked, one corrupted rx frame -> err_cnt_ob increments (the corrupt frame and the frame after it both count as bad); locked_o stays 1.
REQ-038 Locked, 4 consecutive bad frames -> locked_o=0 and a single lock_lost_o pulse on the 4th.
REQ-039 DATA_W=8, generator from 254 -> tx 254,255,0,1; checker accepts the 255->0 wrap as good.
REQ-040 ERR_W=4, 20 bad frames while LOCKED with LOSS_THRESH raised -> err_cnt_ob saturates at 15; err_clear_i with a simultaneous bad frame -> 0.
REQ-041 rx_valid_i toggling 1/0 during locked traffic -> no errors; rst_ir mid-run -> all outputs 0, HUNT.
